fdtd_field_probe: RTL and testbench
===================================

Name: fdtd_field_probe

Overview:
- Observation-side counterpart of the Ez source-injection stage.
- Watches the Ez cell stream produced during each FDTD time step and captures the value at one programmable cell index.
- Captures are decimated by a programmable step interval and saturated to a 32-bit sample.
- Samples are buffered in a FIFO that the host drains through a valid/ready read port.

Parameters:
- data_width, 64, width of the Ez field word (signed fixed point).
- out_width, 32, width of the captured sample.
- idx_width, 16, width of the cell index and cell counter.
- fifo_depth, 16, sample FIFO depth; must be a power of two, at least 2.
- cnt_width, 16, width of the capture count and decimation registers.

Ports:
- clock  in  1  system clock; all logic rises on posedge.
- rst_n  in  1  asynchronous active-low reset.
- arm  in  1  one-cycle pulse that starts a capture run; ignored unless in IDLE.
- abort  in  1  one-cycle pulse that returns the block to IDLE; the FIFO is kept.
- probe_idx  in  idx_width  cell index to sample; latched on arm.
- decim  in  cnt_width  capture every (decim+1)-th step; latched on arm.
- num_samples  in  cnt_width  number of captures in the run (0 means none); latched on arm.
- step_start  in  1  pulse one cycle before the first cell of a time step.
- ez_valid  in  1  qualifies ez_data; one cell per valid cycle.
- ez_data  in  data_width  signed Ez value of the current cell.
- rd_valid  out  1  FIFO not empty.
- rd_data  out  out_width  head sample.
- rd_ready  in  1  host accepts the head sample when high together with rd_valid.
- busy  out  1  FSM not in IDLE.
- done  out  1  one-cycle pulse when the final capture is written.
- overflow  out  1  sticky; set when a capture meets a full FIFO; cleared only by arm.
- fifo_level  out  log2(fifo_depth)+1  current occupancy.

Behaviour:
- Reset: FSM=IDLE; FIFO empty; all counters 0; rd_valid=0, rd_data=0, busy=0, done=0, overflow=0, fifo_level=0.
- FSM states:
  - IDLE: on arm, latch probe_idx, decim and num_samples, clear overflow, load dec_cnt=0 and cap_cnt=0. If num_samples=0, pulse done next cycle and stay in IDLE; otherwise go to WAIT_STEP.
  - WAIT_STEP: on step_start, clear cell_cnt. If dec_cnt==0 go to SCAN; otherwise decrement dec_cnt and stay.
  - SCAN: each ez_valid cycle increments cell_cnt. When ez_valid and cell_cnt==probe_idx, capture the sample, reload dec_cnt=decim and increment cap_cnt. If cap_cnt+1==num_samples, pulse done and go to IDLE; otherwise go to WAIT_STEP.
  - step_start in SCAN before the probe cell is reached (short step): restart cell_cnt=0 and stay in SCAN; no capture for the aborted step.
- abort in any state: go to IDLE next cycle; no done pulse; FIFO contents and overflow are unchanged.
- Saturation: the sample is ez_data clipped to the signed out_width range. 0x7FFF_FFFF if ez_data > 2^31-1; 0x8000_0000 if ez_data < -2^31; otherwise ez_data[31:0].
- Capture latency: the sample is visible at rd_data/rd_valid one cycle after the capturing ez_valid, if the FIFO was empty.
- FIFO: first-word fall-through. A pop happens when rd_valid and rd_ready.
- Simultaneous push and pop:
  - When full: the push succeeds, level is unchanged and overflow is not set.
  - When empty: the pop is not possible and the push proceeds.
- Push when full with no pop: the sample is dropped, overflow is set, and cap_cnt still increments, so the run length is fixed.
- Pointers wrap modulo fifo_depth. fifo_level is exact from 0 to fifo_depth.
- ez_valid and ez_data are ignored outside SCAN.

Optional Feature:
- FDTD_PROBE_TIMESTAMP_EN defined:
  - A step_cnt counter of cnt_width bits counts every step_start while busy; it clears on arm and wraps at 2^cnt_width.
  - Each FIFO entry stores {step_cnt, sample}. rd_data widens to cnt_width+out_width, with the timestamp in the MSBs.
- Not defined: no step counter; rd_data is out_width wide.

Test Plan:
- Basic capture: probe_idx=5, decim=0, num_samples=3, 10 cells per step, ez_data=cell number × 0x100 → three samples of 0x500, one per step; done pulses on the third; busy drops the next cycle.
- Decimation and saturation: decim=2, num_samples=2, probe-cell values 0x1_0000_0000 and -0x1_0000_0000 → captures on steps 0 and 3 only, reading 0x7FFF_FFFF then 0x8000_0000.
- Overflow: fifo_depth=16, rd_ready=0, num_samples=20 → fifo_level saturates at 16; overflow=1; done still pulses after 20 captures; draining returns the first 16 samples in order.
- Simultaneous push/pop when full: hold rd_ready=1 with a full FIFO while a capture occurs → fifo_level stays 16; overflow=0; order is preserved.
- Abort and reset: abort in WAIT_STEP → IDLE with no done pulse, FIFO intact. Assert rst_n=0 mid-SCAN with 4 entries → all outputs 0 immediately and the FIFO is empty.
- Short step: step_start arrives at cell 3 with probe_idx=7 → no capture; the next full step captures cell 7.

Source files
------------

// File: rtl/fdtd_field_probe.sv
// Ez field probe: captures one cell per (decim+1) FDTD steps, saturates it, and queues it in a FWFT FIFO.
// Define FDTD_PROBE_TIMESTAMP_EN to prepend a step counter to every stored sample.
module fdtd_field_probe #(
   parameter int data_width = 64,
   parameter int out_width  = 32,
   parameter int idx_width  = 16,
   parameter int fifo_depth = 16,
   parameter int cnt_width  = 16
) (
   input  logic                          clock,
   input  logic                          rst_n,
   input  logic                          arm,
   input  logic                          abort,
   input  logic [idx_width-1:0]          probe_idx,
   input  logic [cnt_width-1:0]          decim,
   input  logic [cnt_width-1:0]          num_samples,
   input  logic                          step_start,
   input  logic                          ez_valid,
   input  logic [data_width-1:0]         ez_data,
   output logic                          rd_valid,
`ifdef FDTD_PROBE_TIMESTAMP_EN
   output logic [cnt_width+out_width-1:0] rd_data,
`else
   output logic [out_width-1:0]          rd_data,
`endif
   input  logic                          rd_ready,
   output logic                          busy,
   output logic                          done,
   output logic                          overflow,
   output logic [$clog2(fifo_depth):0]   fifo_level
);

   localparam int AW = $clog2(fifo_depth);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] DEPTH_L = LW'(fifo_depth);
`ifdef FDTD_PROBE_TIMESTAMP_EN
   localparam int EW = cnt_width + out_width;
`else
   localparam int EW = out_width;
`endif

   typedef enum logic [1:0] {IDLE, WAIT_STEP, SCAN} state_t;

   state_t                 state_q, state_d;
   logic [idx_width-1:0]   probe_q, probe_d;
   logic [cnt_width-1:0]   decim_q, decim_d;
   logic [cnt_width-1:0]   num_q, num_d;
   logic [cnt_width-1:0]   dec_cnt_q, dec_cnt_d;
   logic [cnt_width-1:0]   cap_cnt_q, cap_cnt_d;
   logic [idx_width-1:0]   cell_cnt_q, cell_cnt_d;
   logic                   done_q, done_d;
   logic                   ovf_q, ovf_d;
   logic                   capture, clr_ovf;

   logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]          level_q, level_d;
   logic [EW-1:0]          mem [fifo_depth];
   logic                   full, pop, push_ok;

   logic [out_width-1:0]   sat_sample;
   logic [EW-1:0]          entry;
   logic [data_width-out_width:0] hi_bits;

   // Value fits when every bit from the output sign bit upward matches.
   assign hi_bits = ez_data[data_width-1:out_width-1];
   always_comb begin
      if (hi_bits == '0 || hi_bits == '1) begin
         sat_sample = ez_data[out_width-1:0];
      end else if (ez_data[data_width-1]) begin
         sat_sample = {1'b1, {(out_width-1){1'b0}}};
      end else begin
         sat_sample = {1'b0, {(out_width-1){1'b1}}};
      end
   end

`ifdef FDTD_PROBE_TIMESTAMP_EN
   logic [cnt_width-1:0] step_cnt_q;
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         step_cnt_q <= '0;
      end else if (state_q == IDLE && arm && !abort) begin
         step_cnt_q <= '0;
      end else if (busy && step_start) begin
         step_cnt_q <= step_cnt_q + 1'b1;
      end
   end
   assign entry = {step_cnt_q, sat_sample};
`else
   assign entry = sat_sample;
`endif

   always_comb begin
      state_d    = state_q;
      probe_d    = probe_q;
      decim_d    = decim_q;
      num_d      = num_q;
      dec_cnt_d  = dec_cnt_q;
      cap_cnt_d  = cap_cnt_q;
      cell_cnt_d = cell_cnt_q;
      done_d     = 1'b0;
      capture    = 1'b0;
      clr_ovf    = 1'b0;
      if (abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (arm) begin
                  probe_d   = probe_idx;
                  decim_d   = decim;
                  num_d     = num_samples;
                  dec_cnt_d = '0;
                  cap_cnt_d = '0;
                  clr_ovf   = 1'b1;
                  if (num_samples == '0) done_d = 1'b1;
                  else                   state_d = WAIT_STEP;
               end
            end
            WAIT_STEP: begin
               if (step_start) begin
                  cell_cnt_d = '0;
                  if (dec_cnt_q == '0) state_d = SCAN;
                  else                 dec_cnt_d = dec_cnt_q - 1'b1;
               end
            end
            SCAN: begin
               // A new step before the probe cell restarts the scan of that step.
               if (step_start) begin
                  cell_cnt_d = '0;
               end else if (ez_valid) begin
                  cell_cnt_d = cell_cnt_q + 1'b1;
                  if (cell_cnt_q == probe_q) begin
                     capture   = 1'b1;
                     dec_cnt_d = decim_q;
                     cap_cnt_d = cap_cnt_q + 1'b1;
                     if (cap_cnt_q + 1'b1 == num_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                     end else begin
                        state_d = WAIT_STEP;
                     end
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign full    = (level_q == DEPTH_L);
   assign pop     = rd_valid && rd_ready;
   assign push_ok = capture && (!full || pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      ovf_d    = ovf_q;
      if (clr_ovf) ovf_d = 1'b0;
      if (capture && full && !pop) ovf_d = 1'b1;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         probe_q    <= '0;
         decim_q    <= '0;
         num_q      <= '0;
         dec_cnt_q  <= '0;
         cap_cnt_q  <= '0;
         cell_cnt_q <= '0;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
      end else begin
         state_q    <= state_d;
         probe_q    <= probe_d;
         decim_q    <= decim_d;
         num_q      <= num_d;
         dec_cnt_q  <= dec_cnt_d;
         cap_cnt_q  <= cap_cnt_d;
         cell_cnt_q <= cell_cnt_d;
         done_q     <= done_d;
         ovf_q      <= ovf_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push_ok) mem[wr_ptr_q] <= entry;
   end

   assign rd_valid   = (level_q != '0);
   assign rd_data    = rd_valid ? mem[rd_ptr_q] : '0;
   assign busy       = (state_q != IDLE);
   assign done       = done_q;
   assign overflow   = ovf_q;
   assign fifo_level = level_q;

endmodule

// File: tb/tb_fdtd_field_probe.sv
// Self-checking bench for fdtd_field_probe: vector table plus scoreboard queue for FIFO output.
module tb_fdtd_field_probe;

   logic        clock = 1'b0;
   logic        rst_n;
   logic        arm, abort;
   logic [15:0] probe_idx, decim, num_samples;
   logic        step_start, ez_valid;
   logic [63:0] ez_data;
   logic        rd_valid, rd_ready;
`ifdef FDTD_PROBE_TIMESTAMP_EN
   logic [47:0] rd_data;
`else
   logic [31:0] rd_data;
`endif
   logic        busy, done, overflow;
   logic [4:0]  fifo_level;

   int n_checks = 0;
   int n_errors = 0;
   int done_cnt = 0;
   logic [31:0] exp_q[$];
   logic vis_after, done_after;

   typedef struct {
      logic [63:0] ez;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs[10];

   always #5 clock = ~clock;

   fdtd_field_probe #(
      .data_width(64), .out_width(32), .idx_width(16), .fifo_depth(16), .cnt_width(16)
   ) dut (
      .clock(clock), .rst_n(rst_n), .arm(arm), .abort(abort),
      .probe_idx(probe_idx), .decim(decim), .num_samples(num_samples),
      .step_start(step_start), .ez_valid(ez_valid), .ez_data(ez_data),
      .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
      .busy(busy), .done(done), .overflow(overflow), .fifo_level(fifo_level)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: compare every sample the host accepts against the expected queue.
   always @(negedge clock) begin
      if (rst_n && done) done_cnt++;
      if (rst_n && rd_valid && rd_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_sample: got %0h expected none", rd_data[31:0]);
         end else begin
            chk("sample", 64'(rd_data[31:0]), 64'(exp_q.pop_front()));
         end
      end
   end

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic arm_run(input int p, input int d, input int n);
      probe_idx   = 16'(p);
      decim       = 16'(d);
      num_samples = 16'(n);
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   task automatic run_step(input int ncells, input int probe, input bit cap, input bit keep,
                           input logic [63:0] pval, input logic [31:0] expv, input bit pulse_rdy);
      step_start = 1'b1;
      tick();
      step_start = 1'b0;
      for (int c = 0; c < ncells; c++) begin
         ez_valid = 1'b1;
         if (c == probe) begin
            ez_data = pval;
            if (cap && keep) exp_q.push_back(expv);
            if (pulse_rdy) rd_ready = 1'b1;
            tick();
            vis_after  = rd_valid;
            done_after = done;
            if (pulse_rdy) rd_ready = 1'b0;
         end else begin
            ez_data = 64'(c) << 8;
            tick();
         end
      end
      ez_valid = 1'b0;
      ez_data  = '0;
      tick();
   endtask

   task automatic drain;
      rd_ready = 1'b1;
      for (int k = 0; k < 64; k++) begin
         if (!rd_valid) break;
         tick();
      end
      chk("drain_empty", 64'(rd_valid), 64'(0));
      rd_ready = 1'b0;
   endtask

   initial begin
      int dc;
      vecs[0] = '{64'h0, 32'h0};
      vecs[1] = '{64'h1, 32'h1};
      vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF};
      vecs[3] = '{64'h0000_0000_7FFF_FFFF, 32'h7FFF_FFFF};
      vecs[4] = '{64'h0000_0000_8000_0000, 32'h7FFF_FFFF};
      vecs[5] = '{64'hFFFF_FFFF_8000_0000, 32'h8000_0000};
      vecs[6] = '{64'hFFFF_FFFF_7FFF_FFFF, 32'h8000_0000};
      vecs[7] = '{64'h8000_0000_0000_0000, 32'h8000_0000};
      vecs[8] = '{64'h7FFF_FFFF_FFFF_FFFF, 32'h7FFF_FFFF};
      vecs[9] = '{64'h0000_0000_0012_3456, 32'h0012_3456};

      rst_n = 1'b0; arm = 1'b0; abort = 1'b0; probe_idx = '0; decim = '0; num_samples = '0;
      step_start = 1'b0; ez_valid = 1'b0; ez_data = '0; rd_ready = 1'b0;
      vis_after = 1'b0; done_after = 1'b0;
      repeat (3) tick();
      chk("rst_rd_valid", 64'(rd_valid), 64'(0));
      chk("rst_rd_data", 64'(rd_data), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_overflow", 64'(overflow), 64'(0));
      chk("rst_level", 64'(fifo_level), 64'(0));
      rst_n = 1'b1;
      tick();

      // num_samples = 0: immediate done, stays idle
      arm_run(3, 0, 0);
      chk("zero_done", 64'(done), 64'(1));
      chk("zero_busy", 64'(busy), 64'(0));
      tick();
      chk("zero_done_pulse", 64'(done), 64'(0));

      // Basic capture
      rd_ready = 1'b1;
      arm_run(5, 0, 3);
      chk("basic_busy", 64'(busy), 64'(1));
      run_step(10, 5, 1, 1, 64'h500, 32'h500, 0);
      chk("basic_latency", 64'(vis_after), 64'(1));
      chk("basic_no_early_done", 64'(done_after), 64'(0));
      run_step(10, 5, 1, 1, 64'h500, 32'h500, 0);
      run_step(10, 5, 1, 1, 64'h500, 32'h500, 0);
      chk("basic_done", 64'(done_after), 64'(1));
      chk("basic_busy_drop", 64'(busy), 64'(0));
      chk("basic_drained", 64'(exp_q.size()), 64'(0));

      // Decimation and saturation
      arm_run(2, 2, 2);
      run_step(4, 2, 1, 1, 64'h1_0000_0000, 32'h7FFF_FFFF, 0);
      run_step(4, 2, 0, 0, 64'h11, 32'h0, 0);
      run_step(4, 2, 0, 0, 64'h22, 32'h0, 0);
      chk("decim_busy", 64'(busy), 64'(1));
      run_step(4, 2, 1, 1, 64'hFFFF_FFFF_0000_0000, 32'h8000_0000, 0);
      chk("decim_done", 64'(done_after), 64'(1));
      chk("decim_drained", 64'(exp_q.size()), 64'(0));

      // Saturation vector table, one capture per step at cell 0
      arm_run(0, 0, 10);
      for (int i = 0; i < 10; i++) begin
         run_step(1, 0, 1, 1, vecs[i].ez, vecs[i].exp, 0);
      end
      chk("table_done", 64'(done_after), 64'(1));
      chk("table_drained", 64'(exp_q.size()), 64'(0));

      // Overflow: 20 captures into a 16-deep FIFO with no reads
      rd_ready = 1'b0;
      dc = done_cnt;
      arm_run(1, 0, 20);
      for (int i = 0; i < 20; i++) begin
         run_step(3, 1, 1, (i < 16), 64'(32'h1000 + i), 32'h1000 + 32'(i), 0);
      end
      chk("ovf_level", 64'(fifo_level), 64'(16));
      chk("ovf_flag", 64'(overflow), 64'(1));
      chk("ovf_done", 64'(done_cnt - dc), 64'(1));
      chk("ovf_busy", 64'(busy), 64'(0));
      drain();
      chk("ovf_sticky", 64'(overflow), 64'(1));
      chk("ovf_drained", 64'(exp_q.size()), 64'(0));

      // Simultaneous push and pop on a full FIFO
      arm_run(1, 0, 17);
      chk("full_ovf_cleared", 64'(overflow), 64'(0));
      for (int i = 0; i < 16; i++) begin
         run_step(3, 1, 1, 1, 64'(32'h2000 + i), 32'h2000 + 32'(i), 0);
      end
      chk("full_level", 64'(fifo_level), 64'(16));
      run_step(3, 1, 1, 1, 64'h2100, 32'h2100, 1);
      chk("pushpop_level", 64'(fifo_level), 64'(16));
      chk("pushpop_ovf", 64'(overflow), 64'(0));
      chk("pushpop_done", 64'(done_after), 64'(1));
      drain();
      chk("pushpop_drained", 64'(exp_q.size()), 64'(0));

      // Abort in WAIT_STEP keeps FIFO, no done
      arm_run(4, 0, 2);
      run_step(6, 4, 1, 1, 64'h4444, 32'h4444, 0);
      dc = done_cnt;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_busy", 64'(busy), 64'(0));
      chk("abort_level", 64'(fifo_level), 64'(1));
      chk("abort_head", 64'(rd_data[31:0]), 64'h4444);
      tick();
      chk("abort_no_done", 64'(done_cnt - dc), 64'(0));
      drain();

      // Short step: restart at cell 3, probe 7 captured on the next full step
      rd_ready = 1'b1;
      arm_run(7, 0, 1);
      run_step(4, 7, 0, 0, 64'h0, 32'h0, 0);
      chk("short_no_capture", 64'(rd_valid), 64'(0));
      chk("short_busy", 64'(busy), 64'(1));
      run_step(10, 7, 1, 1, 64'h700, 32'h700, 0);
      chk("short_done", 64'(done_after), 64'(1));
      chk("short_drained", 64'(exp_q.size()), 64'(0));

      // Asynchronous reset mid-SCAN with 4 entries queued
      rd_ready = 1'b0;
      arm_run(3, 0, 10);
      for (int i = 0; i < 4; i++) begin
         run_step(5, 3, 1, 1, 64'(32'h3000 + i), 32'h3000 + 32'(i), 0);
      end
      chk("pre_rst_level", 64'(fifo_level), 64'(4));
      step_start = 1'b1;
      tick();
      step_start = 1'b0;
      ez_valid = 1'b1;
      ez_data  = 64'h0;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      chk("arst_rd_valid", 64'(rd_valid), 64'(0));
      chk("arst_rd_data", 64'(rd_data), 64'(0));
      chk("arst_busy", 64'(busy), 64'(0));
      chk("arst_done", 64'(done), 64'(0));
      chk("arst_overflow", 64'(overflow), 64'(0));
      chk("arst_level", 64'(fifo_level), 64'(0));
      ez_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_rst_level", 64'(fifo_level), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
